fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline. Drives the IF/ID register consumed by decode: PC_pype0, PCp4_pype0, Instraction_pype and nop. Issues sequential word fetches to instruction memory over a req/ready + rvalid handshake. Buffers returned words in a small FIFO, honours decode's keep (stall), and flushes on a taken branch or jump redirect from EX/MEM.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset release
FIFO_DEPTH, 2, prefetch buffer entries; power of 2, ≥2
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
keep  in  1  stall from hazard unit; hold IF/ID outputs
redirect  in  1  taken branch/jal/jalr; flush and refetch
redirect_pc  in  32  target address of redirect
imem_req  out  1  fetch request valid
imem_addr  out  32  word address of request
imem_ready  in  1  imem accepts request this cycle
imem_rvalid  in  1  response word valid; in-order, one per accepted request
imem_rdata  in  32  response instruction
PC_pype0  out  32  PC of instruction presented to decode
PCp4_pype0  out  32  PC_pype0 + 4
Instraction_pype  out  32  instruction presented to decode
nop  out  1  bubble flag to decode

Behaviour:
- Reset (rst=0, any time, async): fetch_pc=RESET_PC; resp_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; state=IDLE. Outputs: imem_req=0, PC_pype0=0, PCp4_pype0=0, Instraction_pype=NOP_INSTR, nop=1.
- Reset mid-transaction: all in-flight responses are forgotten; imem is reset by the same rst.
- FSM states:
  - IDLE: one cycle after reset release, then go to RUN.
  - RUN: fetch and fill.
  - DRAIN: discard stale responses after a redirect.
- Request rule: imem_req = (state==RUN) && !redirect && (outstanding + fifo_count < FIFO_DEPTH). imem_addr = fetch_pc.
- Handshake: a request is accepted when imem_req && imem_ready; fetch_pc += 4 (wraps modulo 2^32). The address is held stable while unaccepted. A redirect may withdraw an unaccepted request.
- outstanding: +1 on accept, -1 on imem_rvalid; both in the same cycle leaves it unchanged. It never exceeds FIFO_DEPTH.
- Response in RUN: push {resp_pc, imem_rdata} into the FIFO; resp_pc += 4. The request rule guarantees no overflow.
- Response in DRAIN: discard it; drop_cnt -= 1. Go to RUN when drop_cnt reaches 0 (registered; the new count is checked next cycle). With drop_cnt=0 on entry, return to RUN next cycle.
- IF/ID output update, priority order:
  1. redirect=1 (overrides keep): outputs become bubble (Instraction_pype=NOP_INSTR, PCs=0, nop=1). FIFO flushed. fetch_pc=resp_pc={redirect_pc[31:2],2'b00}. drop_cnt = outstanding minus any rvalid this cycle. state=DRAIN.
  2. keep=1: outputs hold; FIFO does not pop; fetching and pushing continue.
  3. FIFO non-empty: pop head; PC_pype0=pc; PCp4_pype0=pc+4; Instraction_pype=instr; nop=0.
  4. FIFO empty: bubble as in item 1.
- A push and a pop in the same cycle are allowed. There is no bypass: minimum latency is rvalid at cycle N, instruction on the outputs after the edge ending cycle N+1.
- imem_rdata is never inspected; decode handles illegal opcodes.

Decomposition:
- Shared package/define file holds NOP_INSTR, RESET_PC and the FSM state encodings (FS_IDLE, FS_RUN, FS_DRAIN) alongside the existing opcode defines.
- Sub-module fetch_fifo: synchronous FIFO, parameterised width 64 (pc+instr) and depth, with push, pop, flush, empty, full and count.

Test Plan:
- Reset then ready=1 with 1-cycle rvalid: addresses 0,4,8 issued. Decode outputs PC 0/4/8, PCp4 4/8/12, nop=0 from the 3rd cycle after release; nop=1 before that.
- keep held 3 cycles while imem streams with FIFO_DEPTH=2: outputs frozen at PC 8. imem_req drops once outstanding+count=2. On release, PCs 12 and 16 follow with no gap and no duplicate.
- redirect with redirect_pc=32'h100 while 2 responses are outstanding: the next output is a bubble. Both stale words are dropped. The next request address is 0x100, and the first valid output is PC 0x100.
- redirect and keep asserted together: redirect wins and a bubble appears the next cycle. redirect_pc=32'h103 fetches 0x100.
- imem_ready=0 for 4 cycles: imem_req stays 1 with imem_addr constant. Decode sees nop=1 after the FIFO empties.
- rst pulled low asynchronously mid-request: outputs go immediately to the reset values (nop=1, Instraction_pype=0x13). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_stage_pkg
// Brief    : Shared fetch-stage constants, FSM encoding and FIFO entry type
// Revision : 1.0
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous prefetch FIFO with flush; DEPTH must be a power of 2
// Revision : 1.0
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !flush && (!full || pop);
  assign w_do_pop  = pop && !flush && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign full     = (r_count == C_FULL);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch feeding IF/ID, with prefetch, stall, redirect
// Revision : 1.0
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        nop
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_fifo_count;
  logic [CW:0]   w_inflight;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Requests in flight plus buffered words never exceed the FIFO size,
  // so every response always has a slot waiting for it.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign imem_req   = (r_state == FS_RUN) && !redirect && !w_fifo_full &&
                      (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr  = r_fetch_pc;
  assign w_accept   = imem_req && imem_ready;
  assign w_push     = imem_rvalid && (r_state == FS_RUN) && !redirect;
  assign w_pop      = !redirect && !keep && !w_fifo_empty;

  assign w_push_entry = '{pc: r_resp_pc, instr: imem_rdata};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = FS_DRAIN;
    end else begin
      case (r_state)
        FS_IDLE:  w_state_nxt = FS_RUN;
        FS_RUN:   w_state_nxt = FS_RUN;
        FS_DRAIN: if (r_drop_cnt == '0) w_state_nxt = FS_RUN;
        default:  w_state_nxt = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= FS_IDLE;
      r_fetch_pc       <= RESET_PC;
      r_resp_pc        <= RESET_PC;
      r_outstanding    <= '0;
      r_drop_cnt       <= '0;
      PC_pype0         <= '0;
      PCp4_pype0       <= '0;
      Instraction_pype <= NOP_INSTR;
      nop              <= 1'b1;
    end else begin
      r_state <= w_state_nxt;

      case ({w_accept, imem_rvalid})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      // Everything still in flight at a redirect belongs to the old path
      if (redirect) begin
        r_fetch_pc <= word_align(redirect_pc);
        r_resp_pc  <= word_align(redirect_pc);
        r_drop_cnt <= r_outstanding - CW'(imem_rvalid);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)   r_resp_pc  <= r_resp_pc + 32'd4;
        if ((r_state == FS_DRAIN) && imem_rvalid && (r_drop_cnt != '0))
          r_drop_cnt <= r_drop_cnt - 1'b1;
      end

      if (w_pop) begin
        PC_pype0         <= w_head.pc;
        PCp4_pype0       <= w_head.pc + 32'd4;
        Instraction_pype <= w_head.instr;
        nop              <= 1'b0;
      end else if (redirect || !keep) begin
        PC_pype0         <= '0;
        PCp4_pype0       <= '0;
        Instraction_pype <= NOP_INSTR;
        nop              <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage with imem model and queue model
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        keep = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_out;
  logic [31:0] pcp4_out;
  logic [31:0] instr_out;
  logic        nop_out;

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .keep             (keep),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .PC_pype0         (pc_out),
    .PCp4_pype0       (pcp4_out),
    .Instraction_pype (instr_out),
    .nop              (nop_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    bit          keep;
    bit          redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          nop;
    logic [31:0] pc;
  } vec_t;

  req_t        iq[$];   // requests accepted by the imem model, in order
  logic [31:0] mq[$];   // PCs of words fetched on the current path, not yet decoded
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          epoch   = 0;
  int          last_due = 0;
  int          lat_max = 1;
  logic [31:0] m_fetch_pc, m_pc, m_pcp4, m_instr;
  logic        m_nop;
  logic        pre_req, prev_pending;
  logic [31:0] pre_addr, prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    iq.delete();
    mq.delete();
    epoch++;
    last_due     = 0;
    m_fetch_pc   = RESET_PC;
    m_pc         = '0;
    m_pcp4       = '0;
    m_instr      = NOP;
    m_nop        = 1'b1;
    prev_pending = 1'b0;
    imem_rvalid  = 1'b0;
  endtask

  // One clock: drive imem response, check request side, clock, check IF/ID
  task automatic step();
    logic        rv, fresh, acc;
    logic [31:0] rv_addr;
    int          e0, lat, due;
    e0 = epoch; rv = 1'b0; fresh = 1'b0; rv_addr = '0;
    if (iq.size() > 0 && iq[0].due <= cyc) begin
      rv      = 1'b1;
      rv_addr = iq[0].addr;
      fresh   = (iq[0].epoch == epoch) && !redirect;
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(rv_addr) : $urandom;
    #1;
    pre_req  = imem_req;
    pre_addr = imem_addr;
    acc      = pre_req && imem_ready;
    if (prev_pending && !redirect) begin
      check("req_held", 32'(pre_req), 32'd1);
      check("addr_held", pre_addr, prev_addr);
    end
    if (pre_req)
      check("req_gate", 32'(redirect || (iq.size() + mq.size() >= DEPTH)), 32'd0);
    if (acc) check("req_addr", pre_addr, m_fetch_pc);
    prev_pending = pre_req && !imem_ready;
    prev_addr    = pre_addr;

    @(posedge clk);
    #1;
    if (acc) m_fetch_pc = m_fetch_pc + 32'd4;
    if (redirect) begin
      mq.delete();
      m_nop = 1'b1; m_pc = '0; m_pcp4 = '0; m_instr = NOP;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      epoch++;
    end else if (!keep) begin
      if (mq.size() > 0) begin
        m_pc = mq.pop_front();
        m_nop = 1'b0; m_pcp4 = m_pc + 32'd4; m_instr = mem_word(m_pc);
      end else begin
        m_nop = 1'b1; m_pc = '0; m_pcp4 = '0; m_instr = NOP;
      end
    end
    if (fresh) mq.push_back(rv_addr);
    check("nop", 32'(nop_out), 32'(m_nop));
    check("pc", pc_out, m_pc);
    check("pcp4", pcp4_out, m_pcp4);
    check("instr", instr_out, m_instr);

    if (rv) void'(iq.pop_front());
    if (acc) begin
      lat = $urandom_range(lat_max, 1);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      iq.push_back('{pre_addr, due, e0});
    end
    cyc++;
  endtask

  initial begin
    vec_t        tv[15];
    logic [31:0] s_addr;

    //              keep redir rpc            req addr           nop pc
    tv[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
    tv[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 32'h0};
    tv[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
    tv[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    tv[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b0, 32'h4};
    tv[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h0};
    tv[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h8};
    tv[7]  = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h0,   1'b1, 32'h0};
    tv[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
    tv[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h0};
    tv[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h0};
    tv[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100};
    tv[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b0, 32'h104};
    tv[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h0};
    tv[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h108};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_nop", 32'(nop_out), 32'd1);
    check("rst_instr", instr_out, NOP);
    check("rst_req", 32'(imem_req), 32'd0);
    rst = 1'b1;

    // Directed table: ready=1, single-cycle response latency
    imem_ready = 1'b1;
    lat_max    = 1;
    for (int i = 0; i < 15; i++) begin
      keep        = tv[i].keep;
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      step();
      check("tbl_req", 32'(pre_req), 32'(tv[i].req));
      if (tv[i].req) check("tbl_addr", pre_addr, tv[i].addr);
      check("tbl_nop", 32'(nop_out), 32'(tv[i].nop));
      check("tbl_pc", pc_out, tv[i].pc);
    end
    keep = 1'b0;
    redirect = 1'b0;

    // imem stalls: request held with a fixed address, decode starves
    repeat (3) step();
    imem_ready = 1'b0;
    s_addr = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 2) check("stall_req", 32'(pre_req), 32'd1);
      if (i == 2) s_addr = pre_addr;
      if (i > 2)  check("stall_addr", pre_addr, s_addr);
    end
    check("stall_nop", 32'(nop_out), 32'd1);

    // Asynchronous reset in the middle of a pending request
    #3;
    rst = 1'b0;
    #1;
    check("arst_nop", 32'(nop_out), 32'd1);
    check("arst_instr", instr_out, NOP);
    check("arst_pc", pc_out, 32'h0);
    check("arst_pcp4", pcp4_out, 32'h0);
    check("arst_req", 32'(imem_req), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    imem_ready = 1'b1;

    // Randomized traffic against the queue model
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      keep        = ($urandom % 100) < 25;
      redirect    = ($urandom % 100) < 6;
      redirect_pc = $urandom;
      imem_ready  = ($urandom % 100) < 70;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
